// File: rtl/gray_conv_arbiter_if.sv
// Request/response bundle for the shared Gray-to-binary converter.
// master drives requests and consumes responses; slave is the converter.
interface gray_conv_arbiter_if #(
  parameter int SIZE = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*SIZE-1:0] req_gray;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic [SIZE-1:0]      rsp_bin;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_ready;
  logic                 busy;

  modport master (
    output req_valid, req_gray, rsp_ready,
    input  req_ready, rsp_valid, rsp_bin, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_gray, rsp_ready,
    output req_ready, rsp_valid, rsp_bin, rsp_id, busy
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared Gray-to-binary converter.
// One registered response slot, refillable in the cycle it drains.
module gray_conv_arbiter #(
  parameter int SIZE = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic clk,
  input  logic rst,
  gray_conv_arbiter_if.slave bus
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t          state_q;
  logic            rsp_valid_q;
  logic [SIZE-1:0] rsp_bin_q;
  logic [SIZE-1:0] rsp_bin_d;
  logic [IDW-1:0]  rsp_id_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  rr_ptr_d;
  logic [IDW-1:0]  win;
  logic            found;
  logic            can_accept;
  logic            xfer;
  logic [SIZE-1:0] gsel;

  // Scan from rr_ptr upward, wrapping at NREQ; first valid wins.
  always_comb begin
    int idx;
    logic [IDW-1:0] idx_w;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_w = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IDW'(idx);
      if (!found && bus.req_valid[idx_w]) begin
        found = 1'b1;
        win   = idx_w;
      end
    end
  end

  always_comb begin
    int nxt;
    nxt = int'(win) + 1;
    if (nxt >= NREQ) nxt = 0;
    rr_ptr_d = IDW'(nxt);
  end

  assign can_accept = (state_q == IDLE) || bus.rsp_ready;
  assign xfer       = !rst && can_accept && found;

  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready[win] = 1'b1;
  end

  assign gsel = bus.req_gray[int'(win)*SIZE +: SIZE];

  always_comb begin
    rsp_bin_d = '0;
    rsp_bin_d[SIZE-1] = gsel[SIZE-1];
    for (int i = SIZE-2; i >= 0; i--)
      rsp_bin_d[i] = rsp_bin_d[i+1] ^ gsel[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_bin_q   <= '0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_bin_q   <= rsp_bin_d;
            rsp_id_q    <= win;
            rr_ptr_q    <= rr_ptr_d;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            if (xfer) begin
              rsp_bin_q <= rsp_bin_d;
              rsp_id_q  <= win;
              rr_ptr_q  <= rr_ptr_d;
            end else begin
              state_q     <= IDLE;
              rsp_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_bin   = rsp_bin_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = rsp_valid_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: directed plan plus random traffic
// checked against a transaction-level reference model.
module tb_gray_conv_arbiter;
  localparam int SIZE = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;

  gray_conv_arbiter_if #(.SIZE(SIZE), .NREQ(NREQ), .IDW(IDW)) bus ();

  gray_conv_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: the pending response and the rotation pointer.
  bit        m_valid;
  bit [7:0]  m_bin;
  int        m_id;
  int        m_ptr;

  function automatic bit [7:0] g2b(input bit [7:0] g);
    bit [7:0] b;
    for (int i = 0; i < SIZE; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit [NREQ-1:0] v,
                      input bit [NREQ*SIZE-1:0] g, input bit rr);
    bit [NREQ-1:0] exp_rdy;
    int w;
    bit [7:0] gw;
    @(negedge clk);
    rst = r;
    bus.req_valid = v;
    bus.req_gray  = g;
    bus.rsp_ready = rr;
    #1;
    exp_rdy = '0;
    w = -1;
    if (!r && (!m_valid || rr)) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (w < 0 && v[j]) w = j;
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    chk("busy", 32'(bus.busy), 32'(m_valid));
    if (m_valid) begin
      chk("rsp_bin", 32'(bus.rsp_bin), 32'(m_bin));
      chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
    end
    if (r) begin
      m_valid = 0; m_bin = 0; m_id = 0; m_ptr = 0;
    end else if (w >= 0 && exp_rdy[w]) begin
      gw = g[w*SIZE +: SIZE];
      m_valid = 1; m_bin = g2b(gw); m_id = w; m_ptr = (w + 1) % NREQ;
    end else if (m_valid && rr) begin
      m_valid = 0;
    end
    @(posedge clk);
  endtask

  function automatic bit [NREQ*SIZE-1:0] on2(input bit [7:0] g);
    bit [NREQ*SIZE-1:0] p;
    p = '0;
    p[2*SIZE +: SIZE] = g;
    return p;
  endfunction

  bit [7:0] t2g [5] = '{8'h02, 8'hC0, 8'hFF, 8'h00, 8'h01};
  bit [7:0] t2b [5] = '{8'h03, 8'h80, 8'hAA, 8'h00, 8'h01};
  bit [1:0] t3id [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    bit [NREQ*SIZE-1:0] allg;
    logic [7:0] hb;
    logic [1:0] hid;
    rst = 1; bus.req_valid = '0; bus.req_gray = '0; bus.rsp_ready = 0;
    m_valid = 0; m_bin = 0; m_id = 0; m_ptr = 0;
    step(1, 4'b0000, '0, 0);
    step(1, 4'b0001, 32'h80, 0);
    #1;
    chk("t1_rst_bin", 32'(bus.rsp_bin), 32'h00);
    chk("t1_rst_id", 32'(bus.rsp_id), 32'h0);
    // Test 1: first accept and one-cycle latency
    step(0, 4'b0001, 32'h80, 0);
    #1;
    chk("t1_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_bin", 32'(bus.rsp_bin), 32'hFF);
    step(0, 4'b0000, '0, 1);
    // Test 2: conversion table on requester 2
    for (int i = 0; i < 5; i++) begin
      step(0, 4'b0100, on2(t2g[i]), 1);
      #1;
      chk("t2_bin", 32'(bus.rsp_bin), 32'(t2b[i]));
      chk("t2_id", 32'(bus.rsp_id), 32'h2);
    end
    step(0, 4'b0000, '0, 1);
    step(1, 4'b0000, '0, 0);
    // Test 3: full rotation, back-to-back
    allg = 32'h44332211;
    for (int i = 0; i < 6; i++) begin
      step(0, 4'b1111, allg, 1);
      #1;
      chk("t3_id", 32'(bus.rsp_id), 32'(t3id[i]));
    end
    // Test 4: backpressure holds the slot
    hb = bus.rsp_bin; hid = bus.rsp_id;
    for (int i = 0; i < 5; i++) step(0, 4'b1111, allg, 0);
    #1;
    chk("t4_hold_bin", 32'(bus.rsp_bin), 32'(hb));
    chk("t4_hold_id", 32'(bus.rsp_id), 32'(hid));
    step(0, 4'b1111, allg, 1);
    #1;
    chk("t4_next_id", 32'(bus.rsp_id), 32'h2);
    // Test 5: pointer wrap after requester 3
    step(0, 4'b1000, allg, 1);
    step(0, 4'b0101, allg, 1);
    #1;
    chk("t5_first", 32'(bus.rsp_id), 32'h0);
    step(0, 4'b0101, allg, 1);
    #1;
    chk("t5_second", 32'(bus.rsp_id), 32'h2);
    // Test 6: reset while holding a response
    step(0, 4'b0010, allg, 0);
    step(1, 4'b1111, allg, 0);
    #1;
    chk("t6_drop", 32'(bus.rsp_valid), 32'h0);
    step(0, 4'b0010, allg, 1);
    #1;
    chk("t6_id", 32'(bus.rsp_id), 32'h1);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0),
           4'($urandom),
           {$urandom, $urandom},
           ($urandom_range(0, 3) != 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
